// File: rtl/mips_control_fsm_if.sv
// Control-unit bus: instruction/memory/ALU status in, datapath selects and enables out.
interface mips_control_fsm_if;
    logic [31:0] instr;
    logic        mem_waitrequest;
    logic        ALUResult0;
    logic        PCZero;

    logic [4:0]  ALUControl;
    logic [1:0]  ALUSrcA;
    logic [2:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        RegDst;
    logic        MemtoReg;
    logic        active;
    logic        illegal;

    // Control unit side.
    modport master (
        input  instr, mem_waitrequest, ALUResult0, PCZero,
        output ALUControl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IRWrite,
               RegWrite, MemRead, MemWrite, IorD, RegDst, MemtoReg, active, illegal
    );

    // Datapath side.
    modport slave (
        output instr, mem_waitrequest, ALUResult0, PCZero,
        input  ALUControl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IRWrite,
               RegWrite, MemRead, MemWrite, IorD, RegDst, MemtoReg, active, illegal
    );
endinterface

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch, decode, execute, memory and
// writeback, driving the datapath selects, enables and the ALUControl bus.
module mips_control_fsm (
    input  logic               clk,
    input  logic               rst_n,
    mips_control_fsm_if.master bus
);
    // state   | meaning
    // FETCH   | read instruction at PC, IR <= mem, PC <= PC + 4
    // DECODE  | register read, branch target into ALUOut, J resolves here
    // EXEC    | ALU op, address calc, branch compare or JR
    // MEM     | data access at ALUOut for LW/SW
    // WB      | register file write
    // HALTED  | PC reached zero or illegal instruction; only reset leaves
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_t;

    localparam logic [4:0] ALU_AND   = 5'b00000;
    localparam logic [4:0] ALU_OR    = 5'b00001;
    localparam logic [4:0] ALU_ADD   = 5'b00010;
    localparam logic [4:0] ALU_XOR   = 5'b00011;
    localparam logic [4:0] ALU_SLL   = 5'b00100;
    localparam logic [4:0] ALU_SRL   = 5'b00101;
    localparam logic [4:0] ALU_SUB   = 5'b00110;
    localparam logic [4:0] ALU_SLT   = 5'b00111;
    localparam logic [4:0] ALU_SRA   = 5'b01000;
    localparam logic [4:0] ALU_SLTU  = 5'b01001;
    localparam logic [4:0] ALU_EQ    = 5'b01010;
    localparam logic [4:0] ALU_PASSA = 5'b01110;
    localparam logic [4:0] ALU_LUI   = 5'b10100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS    = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [2:0] SRCB_RT     = 3'd0;
    localparam logic [2:0] SRCB_FOUR   = 3'd1;
    localparam logic [2:0] SRCB_IMM_SE = 3'd2;
    localparam logic [2:0] SRCB_BR_OFS = 3'd3;
    localparam logic [2:0] SRCB_IMM_ZE = 3'd4;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    state_t     state;
    state_t     next_state;
    logic       illegal_q;
    logic       set_illegal;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    logic [4:0] r_op;
    logic       r_alu;
    logic       r_shift;
    logic [4:0] i_op;
    logic [2:0] i_src_b;
    logic       i_alu;

    logic       is_rtype;
    logic       is_r_alu;
    logic       is_jr;
    logic       is_i_alu;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_legal;
    logic       branch_taken;

    logic [4:0] alu_control;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    // Register and immediate fields are consumed by the datapath, not here.
    assign unused_instr_bits = ^bus.instr[25:6];

    // Map funct and opcode onto ALU operations for the register and immediate ALU forms.
    always_comb begin
        r_op    = ALU_AND;
        r_alu   = 1'b0;
        r_shift = 1'b0;
        case (funct)
            FN_ADDU: begin r_op = ALU_ADD;  r_alu = 1'b1; end
            FN_SUBU: begin r_op = ALU_SUB;  r_alu = 1'b1; end
            FN_AND:  begin r_op = ALU_AND;  r_alu = 1'b1; end
            FN_OR:   begin r_op = ALU_OR;   r_alu = 1'b1; end
            FN_XOR:  begin r_op = ALU_XOR;  r_alu = 1'b1; end
            FN_SLT:  begin r_op = ALU_SLT;  r_alu = 1'b1; end
            FN_SLTU: begin r_op = ALU_SLTU; r_alu = 1'b1; end
            FN_SLL:  begin r_op = ALU_SLL;  r_alu = 1'b1; r_shift = 1'b1; end
            FN_SRL:  begin r_op = ALU_SRL;  r_alu = 1'b1; r_shift = 1'b1; end
            FN_SRA:  begin r_op = ALU_SRA;  r_alu = 1'b1; r_shift = 1'b1; end
            default: ;
        endcase

        i_op    = ALU_AND;
        i_src_b = SRCB_IMM_SE;
        i_alu   = 1'b0;
        case (opcode)
            OP_ADDIU: begin i_op = ALU_ADD;  i_src_b = SRCB_IMM_SE; i_alu = 1'b1; end
            OP_SLTI:  begin i_op = ALU_SLT;  i_src_b = SRCB_IMM_SE; i_alu = 1'b1; end
            OP_SLTIU: begin i_op = ALU_SLTU; i_src_b = SRCB_IMM_SE; i_alu = 1'b1; end
            OP_ANDI:  begin i_op = ALU_AND;  i_src_b = SRCB_IMM_ZE; i_alu = 1'b1; end
            OP_ORI:   begin i_op = ALU_OR;   i_src_b = SRCB_IMM_ZE; i_alu = 1'b1; end
            OP_XORI:  begin i_op = ALU_XOR;  i_src_b = SRCB_IMM_ZE; i_alu = 1'b1; end
            OP_LUI:   begin i_op = ALU_LUI;  i_src_b = SRCB_IMM_ZE; i_alu = 1'b1; end
            default: ;
        endcase
    end

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_r_alu = is_rtype && r_alu;
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_i_alu = i_alu;
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_bne   = (opcode == OP_BNE);
    assign is_j     = (opcode == OP_J);
    assign is_legal = is_r_alu || is_jr || is_i_alu || is_lw || is_sw ||
                      is_beq || is_bne || is_j;

    // BEQ takes on a set compare bit, BNE on a clear one.
    assign branch_taken = is_beq ? bus.ALUResult0 : !bus.ALUResult0;

    // Next state and datapath controls; everything is held at zero while in reset.
    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        alu_control = ALU_AND;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RT;
        pc_source   = PCSRC_ALU;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    if (bus.PCZero) begin
                        next_state = HALTED;
                    end else begin
                        mem_read    = 1'b1;
                        alu_src_a   = SRCA_PC;
                        alu_src_b   = SRCB_FOUR;
                        alu_control = ALU_ADD;
                        if (!bus.mem_waitrequest) begin
                            ir_write   = 1'b1;
                            pc_write   = 1'b1;
                            pc_source  = PCSRC_ALU;
                            next_state = DECODE;
                        end
                    end
                end
                DECODE: begin
                    alu_src_a   = SRCA_PC;
                    alu_src_b   = SRCB_BR_OFS;
                    alu_control = ALU_ADD;
                    if (is_j) begin
                        pc_write   = 1'b1;
                        pc_source  = PCSRC_JUMP;
                        next_state = FETCH;
                    end else if (!is_legal) begin
                        set_illegal = 1'b1;
                        next_state  = HALTED;
                    end else begin
                        next_state = EXEC;
                    end
                end
                EXEC: begin
                    alu_src_a  = SRCA_RS;
                    next_state = FETCH;
                    if (is_r_alu) begin
                        alu_src_a   = r_shift ? SRCA_SHAMT : SRCA_RS;
                        alu_src_b   = SRCB_RT;
                        alu_control = r_op;
                        next_state  = WB;
                    end else if (is_i_alu) begin
                        alu_src_b   = i_src_b;
                        alu_control = i_op;
                        next_state  = WB;
                    end else if (is_lw || is_sw) begin
                        alu_src_b   = SRCB_IMM_SE;
                        alu_control = ALU_ADD;
                        next_state  = MEM;
                    end else if (is_beq || is_bne) begin
                        alu_src_b   = SRCB_RT;
                        alu_control = ALU_EQ;
                        if (branch_taken) begin
                            pc_write  = 1'b1;
                            pc_source = PCSRC_ALUOUT;
                        end
                    end else if (is_jr) begin
                        alu_control = ALU_PASSA;
                        pc_write    = 1'b1;
                        pc_source   = PCSRC_ALU;
                    end
                end
                MEM: begin
                    iord      = 1'b1;
                    mem_read  = is_lw;
                    mem_write = is_sw;
                    if (!bus.mem_waitrequest) begin
                        next_state = is_lw ? WB : FETCH;
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_lw;
                    reg_dst    = is_rtype;
                    next_state = FETCH;
                end
                HALTED: begin
                    next_state = HALTED;
                end
                default: begin
                    next_state = HALTED;
                end
            endcase
        end
    end

    // State register and sticky illegal flag; a low rst_n at the edge restarts in FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign bus.ALUControl = alu_control;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.PCSource   = pc_source;
    assign bus.PCWrite    = pc_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.IorD       = iord;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.active     = rst_n && (state != HALTED);
    assign bus.illegal    = rst_n && illegal_q;
endmodule

// File: tb/tb_mips_control_fsm.sv
// Bench for mips_control_fsm: instruction-level model compared every cycle,
// plus directed literal checks on latency and key control pulses.
module tb_mips_control_fsm;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mips_control_fsm_if bus ();

    mips_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] alu_control;
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       active;
        logic       illegal;
    } obs_t;

    typedef struct packed {
        logic [3:0] kind;
        logic [4:0] op;
        logic [2:0] src_b;
    } info_t;

    localparam logic [3:0] K_R   = 4'd0;
    localparam logic [3:0] K_SH  = 4'd1;
    localparam logic [3:0] K_JR  = 4'd2;
    localparam logic [3:0] K_IS  = 4'd3;
    localparam logic [3:0] K_LW  = 4'd4;
    localparam logic [3:0] K_SW  = 4'd5;
    localparam logic [3:0] K_BEQ = 4'd6;
    localparam logic [3:0] K_BNE = 4'd7;
    localparam logic [3:0] K_J   = 4'd8;
    localparam logic [3:0] K_BAD = 4'd9;

    // Instruction tables: R-type funct -> op (last three are shifts), I-type opcode -> op, B source.
    localparam logic [5:0] R_FUNCT [10] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
    localparam logic [4:0] R_OP    [10] = '{5'd2, 5'd6, 5'd0, 5'd1, 5'd3, 5'd7, 5'd9, 5'd4, 5'd5, 5'd8};
    localparam logic [5:0] I_OPC   [7]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    localparam logic [4:0] I_OP    [7]  = '{5'd2, 5'd7, 5'd9, 5'd0, 5'd1, 5'd3, 5'd20};
    localparam logic [2:0] I_SRCB  [7]  = '{3'd2, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4};

    localparam int ST_F = 0;
    localparam int ST_D = 1;
    localparam int ST_E = 2;
    localparam int ST_M = 3;
    localparam int ST_W = 4;
    localparam int ST_H = 5;

    int   m_stage = ST_F;
    logic m_ill   = 1'b0;

    int   total = 0;
    int   bad   = 0;
    obs_t exp_o;
    obs_t act_o;
    obs_t lg [64];
    int   act_cnt;
    int   en_cnt;
    int   rw_cnt;
    int   mr_cnt;

    function automatic info_t classify(input logic [31:0] ins);
        info_t r;
        r.kind  = K_BAD;
        r.op    = 5'd0;
        r.src_b = 3'd0;
        if (ins[31:26] == 6'h00) begin
            if (ins[5:0] == 6'h08) r.kind = K_JR;
            for (int k = 0; k < 10; k++) begin
                if (R_FUNCT[k] == ins[5:0]) begin
                    r.op   = R_OP[k];
                    r.kind = (k >= 7) ? K_SH : K_R;
                end
            end
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (I_OPC[k] == ins[31:26]) begin
                    r.kind  = K_IS;
                    r.op    = I_OP[k];
                    r.src_b = I_SRCB[k];
                end
            end
            case (ins[31:26])
                6'h23:   r.kind = K_LW;
                6'h2B:   r.kind = K_SW;
                6'h04:   r.kind = K_BEQ;
                6'h05:   r.kind = K_BNE;
                6'h02:   r.kind = K_J;
                default: ;
            endcase
        end
        return r;
    endfunction

    // Instruction-level progress: which phase the current instruction is in.
    always @(posedge clk) begin
        info_t c;
        c = classify(bus.instr);
        if (!rst_n) begin
            m_stage <= ST_F;
            m_ill   <= 1'b0;
        end else begin
            case (m_stage)
                ST_F: if (bus.PCZero) m_stage <= ST_H;
                      else if (!bus.mem_waitrequest) m_stage <= ST_D;
                ST_D: if (c.kind == K_J) m_stage <= ST_F;
                      else if (c.kind == K_BAD) begin m_stage <= ST_H; m_ill <= 1'b1; end
                      else m_stage <= ST_E;
                ST_E: if (c.kind == K_LW || c.kind == K_SW) m_stage <= ST_M;
                      else if (c.kind == K_BEQ || c.kind == K_BNE || c.kind == K_JR) m_stage <= ST_F;
                      else m_stage <= ST_W;
                ST_M: if (!bus.mem_waitrequest) m_stage <= (c.kind == K_LW) ? ST_W : ST_F;
                ST_W: m_stage <= ST_F;
                default: m_stage <= ST_H;
            endcase
        end
    end

    function automatic obs_t model_out();
        obs_t  o;
        info_t c;
        logic  taken;
        o = '0;
        c = classify(bus.instr);
        if (rst_n) begin
            o.active  = (m_stage != ST_H);
            o.illegal = m_ill;
            case (m_stage)
                ST_F: if (!bus.PCZero) begin
                    o.mem_read    = 1'b1;
                    o.alu_src_b   = 3'd1;
                    o.alu_control = 5'd2;
                    o.ir_write    = !bus.mem_waitrequest;
                    o.pc_write    = !bus.mem_waitrequest;
                end
                ST_D: begin
                    o.alu_src_b   = 3'd3;
                    o.alu_control = 5'd2;
                    if (c.kind == K_J) begin
                        o.pc_write  = 1'b1;
                        o.pc_source = 2'd2;
                    end
                end
                ST_E: begin
                    o.alu_src_a = 2'd1;
                    if (c.kind == K_R || c.kind == K_SH || c.kind == K_IS) begin
                        o.alu_control = c.op;
                        o.alu_src_b   = c.src_b;
                        if (c.kind == K_SH) o.alu_src_a = 2'd2;
                    end else if (c.kind == K_LW || c.kind == K_SW) begin
                        o.alu_src_b   = 3'd2;
                        o.alu_control = 5'd2;
                    end else if (c.kind == K_BEQ || c.kind == K_BNE) begin
                        o.alu_control = 5'b01010;
                        taken = (c.kind == K_BEQ) ? bus.ALUResult0 : !bus.ALUResult0;
                        o.pc_write  = taken;
                        o.pc_source = taken ? 2'd1 : 2'd0;
                    end else if (c.kind == K_JR) begin
                        o.alu_control = 5'b01110;
                        o.pc_write    = 1'b1;
                    end
                end
                ST_M: begin
                    o.iord      = 1'b1;
                    o.mem_read  = (c.kind == K_LW);
                    o.mem_write = (c.kind == K_SW);
                end
                ST_W: begin
                    o.reg_write  = 1'b1;
                    o.mem_to_reg = (c.kind == K_LW);
                    o.reg_dst    = (c.kind == K_R || c.kind == K_SH);
                end
                default: ;
            endcase
        end
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.alu_control = bus.ALUControl;
        o.alu_src_a   = bus.ALUSrcA;
        o.alu_src_b   = bus.ALUSrcB;
        o.pc_source   = bus.PCSource;
        o.pc_write    = bus.PCWrite;
        o.ir_write    = bus.IRWrite;
        o.reg_write   = bus.RegWrite;
        o.mem_read    = bus.MemRead;
        o.mem_write   = bus.MemWrite;
        o.iord        = bus.IorD;
        o.reg_dst     = bus.RegDst;
        o.mem_to_reg  = bus.MemtoReg;
        o.active      = bus.active;
        o.illegal     = bus.illegal;
        return o;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Runs one instruction from FETCH until back in FETCH (or HALTED), logging DUT outputs.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic r0, input int want_cycles, input string nm);
        int cyc  = 0;
        int fc   = 0;
        int mc   = 0;
        bit left = 1'b0;
        bit done = 1'b0;
        bus.instr      = ins;
        bus.ALUResult0 = r0;
        while (!done && cyc < 60) begin
            bus.mem_waitrequest = ((m_stage == ST_F) && (fc < fw)) || ((m_stage == ST_M) && (mc < mw));
            if (bus.mem_waitrequest) begin
                if (m_stage == ST_F) fc++;
                else mc++;
            end
            @(negedge clk);
            lg[cyc] = dut_obs();
            cyc++;
            @(posedge clk);
            #1;
            if (m_stage != ST_F) left = 1'b1;
            if ((left && m_stage == ST_F) || m_stage == ST_H) done = 1'b1;
        end
        bus.mem_waitrequest = 1'b0;
        check({nm, "_cycles"}, cyc, want_cycles);
    endtask

    initial begin
        bus.instr           = 32'h0;
        bus.mem_waitrequest = 1'b0;
        bus.ALUResult0      = 1'b0;
        bus.PCZero          = 1'b0;

        fork
            forever begin
                @(negedge clk);
                exp_o = model_out();
                act_o = dut_obs();
                total++;
                if (act_o !== exp_o) begin
                    bad++;
                    $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act_o, exp_o);
                end
            end
        join_none

        @(negedge clk);
        check("reset_outputs", dut_obs(), 22'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(32'h00221821, 0, 0, 1'b0, 4, "addu");
        check("addu_exec_ctrl", {lg[2].alu_control, lg[2].alu_src_a, lg[2].alu_src_b}, {5'b00010, 2'd1, 3'd0});
        check("addu_wb", {lg[3].reg_write, lg[3].reg_dst}, 2'b11);
        rw_cnt = 0;
        for (int k = 0; k < 4; k++) rw_cnt += int'(lg[k].reg_write);
        check("addu_regwrite_count", rw_cnt, 1);

        run_instr(32'h8C430004, 2, 2, 1'b0, 9, "lw");
        rw_cnt = 0;
        mr_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            rw_cnt += int'(lg[k].reg_write);
            mr_cnt += int'(lg[k].mem_read);
        end
        check("lw_memread_cycles", mr_cnt, 6);
        check("lw_regwrite_count", rw_cnt, 1);
        check("lw_wb", {lg[8].reg_write, lg[8].mem_to_reg, lg[8].reg_dst}, 3'b110);

        run_instr(32'h10220003, 0, 0, 1'b1, 3, "beq_t");
        check("beq_taken", {lg[2].pc_write, lg[2].pc_source}, 3'b101);
        run_instr(32'h10220003, 0, 0, 1'b0, 3, "beq_nt");
        check("beq_not_taken", {lg[2].pc_write, lg[2].pc_source}, 3'b000);
        run_instr(32'h14220003, 0, 0, 1'b1, 3, "bne_nt");
        check("bne_not_taken", {lg[2].pc_write, lg[2].pc_source}, 3'b000);
        run_instr(32'h14220003, 0, 0, 1'b0, 3, "bne_t");
        check("bne_taken", {lg[2].pc_write, lg[2].pc_source}, 3'b101);

        run_instr(32'h00031080, 0, 0, 1'b0, 4, "sll");
        check("sll_exec", {lg[2].alu_control, lg[2].alu_src_a}, {5'b00100, 2'd2});
        run_instr(32'h3062000F, 0, 0, 1'b0, 4, "andi");
        check("andi_exec", {lg[2].alu_control, lg[2].alu_src_b, lg[3].reg_dst}, {5'b00000, 3'd4, 1'b0});
        run_instr(32'h03E00008, 0, 0, 1'b0, 3, "jr");
        check("jr_exec", {lg[2].alu_control, lg[2].pc_write, lg[2].pc_source}, {5'b01110, 1'b1, 2'd0});

        // SW stalled in MEM, aborted by reset.
        bus.instr = 32'hAC430004;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        bus.mem_waitrequest = 1'b1;
        @(negedge clk);
        check("sw_mem_stall", {bus.MemWrite, bus.IorD}, 2'b11);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("sw_reset_enables", {bus.MemWrite, bus.MemRead, bus.RegWrite, bus.active}, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mem_waitrequest = 1'b0;
        @(negedge clk);
        check("sw_restart_fetch", {bus.MemRead, bus.IRWrite, bus.PCWrite, bus.IorD}, 4'b1110);
        rw_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            rw_cnt += int'(bus.RegWrite);
        end
        check("sw_no_regwrite", rw_cnt, 0);
        @(posedge clk);
        #1;

        run_instr(32'h08000000, 0, 0, 1'b0, 2, "j");
        check("j_decode", {lg[1].pc_write, lg[1].pc_source}, 3'b110);
        bus.PCZero = 1'b1;
        @(negedge clk);
        check("halt_fetch", {bus.MemRead, bus.IRWrite, bus.PCWrite, bus.active}, 4'b0001);
        @(posedge clk);
        #1;
        bus.PCZero = 1'b0;
        act_cnt = 0;
        en_cnt  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            act_cnt += int'(bus.active);
            en_cnt  += int'(bus.PCWrite) + int'(bus.IRWrite) + int'(bus.RegWrite) +
                       int'(bus.MemRead) + int'(bus.MemWrite);
            @(posedge clk);
            #1;
        end
        check("halted_active", act_cnt, 0);
        check("halted_enables", en_cnt, 0);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(32'hFC000000, 0, 0, 1'b0, 2, "bad_op");
        @(negedge clk);
        check("illegal_set", {bus.illegal, bus.active}, 2'b10);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("illegal_in_reset", {bus.illegal, bus.active}, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("illegal_cleared_fetch", {bus.illegal, bus.active, bus.MemRead}, 3'b011);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_control_fsm.md
# mips_control_fsm

Multicycle control unit for the MIPS datapath: it sequences each instruction through fetch, decode, execute, memory and writeback. It is the producer side of the 5-bit `ALUControl` bus and drives all datapath selects and write enables. It sits between the instruction register and memory handshake on one side and the ALU, register file and PC on the other.

## Interface
- Parameters: none.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `instr` input 32: current instruction register contents; valid from DECODE onward.
- `mem_waitrequest` input 1: memory stall; the access completes in the cycle where it is 0.
- `ALUResult0` input 1: bit 0 of the ALU result; the compare outcome in branch EXEC.
- `PCZero` input 1: datapath PC == 0.
- `ALUControl` output 5: operation code, encodings listed under Operation.
- `ALUSrcA` output 2: 0=PC, 1=rs, 2=zero-extended shamt.
- `ALUSrcB` output 3: 0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2, 4=zero-ext imm.
- `PCSource` output 2: 0=ALU result, 1=ALUOut register, 2=jump target {PC[31:28],instr[25:0],2'b00}.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemRead`, `MemWrite` output 1 each: enables.
- `IorD` output 1: memory address select, 0=PC, 1=ALUOut.
- `RegDst` output 1: 0=rt, 1=rd.
- `MemtoReg` output 1: 0=ALUOut, 1=memory data.
- `active` output 1: high unless HALTED or in reset.
- `illegal` output 1: sticky; set when an unsupported instruction is decoded.

## Operation
- ALUControl encodings:
  - AND=00000, OR=00001, ADD=00010, XOR=00011.
  - SLL=00100, SRL=00101, SUB=00110, SLT=00111, SRA=01000, SLTU=01001.
  - EQ=01010 (result 1 when A==B), PASSA=01110, LUI=10100.
- Supported instructions:
  - R-type (funct): ADDU 21h, SUBU 23h, AND 24h, OR 25h, XOR 26h, SLT 2Ah, SLTU 2Bh, SLL 00h, SRL 02h, SRA 03h, JR 08h.
  - I-type: ADDIU 09h, SLTI 0Ah, SLTIU 0Bh, ANDI 0Ch, ORI 0Dh, XORI 0Eh, LUI 0Fh, LW 23h, SW 2Bh, BEQ 04h, BNE 05h.
  - J-type: J 02h.
- States: FETCH, DECODE, EXEC, MEM, WB, HALTED. The 3-bit state register is the only sequential state besides `illegal`.
- FETCH:
  - If `PCZero`: go to HALTED with all enables 0.
  - Otherwise: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUControl=ADD.
  - Stay in FETCH while `mem_waitrequest`=1.
  - When `mem_waitrequest`=0: IRWrite=1, PCWrite=1, PCSource=0, then go to DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ALUControl=ADD; the branch target is latched into ALUOut by the datapath.
  - J: PCWrite=1, PCSource=2, then FETCH.
  - Unsupported opcode or funct: set `illegal`, go to HALTED.
  - All other instructions: EXEC.
- EXEC:
  - R-type ALU ops: ALUSrcA=1 (shifts use 2), ALUSrcB=0, op per funct; then WB.
  - ADDIU/SLTI/SLTIU: ALUSrcB=2 with ADD/SLT/SLTU; then WB.
  - ANDI/ORI/XORI: ALUSrcB=4; then WB.
  - LUI: ALUSrcB=4, ALUControl=LUI; then WB.
  - LW/SW: ALUSrcA=1, ALUSrcB=2, ALUControl=ADD; then MEM.
  - BEQ/BNE: ALUSrcA=1, ALUSrcB=0, ALUControl=EQ. Branch is taken when ALUResult0==1 (BEQ) or ALUResult0==0 (BNE); if taken, PCWrite=1, PCSource=1. Then FETCH.
  - JR: ALUSrcA=1, ALUControl=PASSA, PCWrite=1, PCSource=0; then FETCH.
- MEM:
  - IorD=1; MemRead=1 for LW, MemWrite=1 for SW.
  - Hold the state while `mem_waitrequest`=1.
  - On completion: LW goes to WB, SW goes to FETCH.
- WB:
  - RegWrite=1.
  - LW: MemtoReg=1, RegDst=0.
  - I-type: RegDst=0.
  - R-type: RegDst=1.
  - Then FETCH.
- HALTED: absorbing state; all enables 0, `active`=0. Only `rst_n` exits it.

## Timing
- Outputs are combinational from state, `instr`, `mem_waitrequest` and `ALUResult0`. The state changes only on a clk edge.
- Reset:
  - While `rst_n`=0 at an edge, the next state is FETCH and `illegal` is cleared.
  - During any cycle with `rst_n`=0, all enables, `active` and `illegal` outputs are forced to 0. Selects and ALUControl are forced to 0 as well.
- A reset asserted mid-MEM or mid-stall aborts the access; no write enable is asserted in that cycle.
- Latency with zero wait:
  - ALU instructions: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch and JR: 3 cycles.
  - J: 2 cycles.
  - Each stalled cycle adds exactly one cycle.
- Enables are asserted for exactly one cycle per transition; none are asserted in stall cycles except MemRead/MemWrite.
- `PCZero` is sampled only in FETCH.

## Test plan
- Reset, then ADDU (instr=00221821h), no waits -> ALUControl=00010 with ALUSrcA=1, ALUSrcB=0 in EXEC. RegWrite=1 with RegDst=1 exactly in cycle 4, then FETCH.
- LW (8C430004h) with `mem_waitrequest` high for 2 cycles in both FETCH and MEM -> total 9 cycles. MemRead is held during the stalls; RegWrite=1 with MemtoReg=1 once.
- BEQ (10220003h) with ALUResult0=1 -> PCWrite=1, PCSource=1 in EXEC. Repeat with ALUResult0=0 -> no PCWrite. Repeat as BNE -> inverse outcomes.
- J 0 followed by `PCZero`=1 -> HALTED on the next FETCH. `active` falls and all enables stay 0 for 10 further cycles.
- Opcode 3Fh -> `illegal`=1 after DECODE, state HALTED. `rst_n` low for one edge clears `illegal` and restarts in FETCH.
- SW with `mem_waitrequest` held high and `rst_n` pulsed low during MEM -> MemWrite=0 during reset, next state FETCH, no RegWrite.
